// File: rtl/int_sqrt_iter_pkg.sv
// Shared constants for the iterative integer square-root unit:
// FSM state codes and root-width / iteration-count helpers.
package int_sqrt_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int rootWidth(input int n, input int frac);
    return (n + 32'sd1) / 32'sd2 + frac;
  endfunction

  function automatic int iterCount(input int n, input int frac, input int k);
    return rootWidth(n, frac) / k;
  endfunction

endpackage

// File: rtl/int_sqrt_iter_if.sv
// Radicand-in / root-out handshake bundle for int_sqrt_iter.
interface int_sqrt_iter_if #(
  parameter int N = 32,
  parameter int R = 16
);
  logic         inValid;
  logic         inReady;
  logic [N-1:0] in;
  logic         outValid;
  logic         outReady;
  logic [R-1:0] root;
  logic [R:0]   rem;

  modport master (output inValid, in, outReady, input inReady, outValid, root, rem);
  modport slave  (input inValid, in, outReady, output inReady, outValid, root, rem);
endinterface

// File: rtl/int_sqrt_iter_digit.sv
// One restoring radix-2 square-root digit step (purely combinational).
module int_sqrt_digit #(
  parameter int R = 16
) (
  input  logic [R+1:0] part_rem,
  input  logic [R-1:0] part_root,
  input  logic [1:0]   pair,
  output logic [R+1:0] next_rem,
  output logic [R-1:0] next_root
);

  logic [R+3:0] shifted_s;
  logic [R+3:0] trial_s;
  logic [R+1:0] diff_s;
  logic         ge_s;

  // Compare at full width so the decision never depends on truncated bits.
  always_comb begin
    shifted_s = {part_rem, pair};
    trial_s   = {2'b00, part_root, 2'b01};
    ge_s      = (shifted_s >= trial_s);
    diff_s    = shifted_s[R+1:0] - trial_s[R+1:0];
    if (ge_s) begin
      next_rem  = diff_s;
      next_root = (part_root << 1) | R'(1'b1);
    end else begin
      next_rem  = shifted_s[R+1:0];
      next_root = part_root << 1;
    end
  end

endmodule

// File: rtl/int_sqrt_iter.sv
// Iterative integer square root: K restoring digits per cycle, valid/ready on
// both sides, remainder output and optional fractional root bits.
module int_sqrt_iter
  import int_sqrt_pkg::*;
#(
  parameter int N    = 32,
  parameter int FRAC = 0,
  parameter int K    = 1
) (
  input logic           clk,
  input logic           rstN,
  int_sqrt_iter_if.slave bus
);

  localparam int R     = rootWidth(N, FRAC);
  localparam int ITERS = iterCount(N, FRAC, K);
  localparam int CW    = $clog2(ITERS + 1);

  if ((R % K) != 0) begin : g_bad_k
    $error("int_sqrt_iter: K must divide the root width");
  end

  logic [1:0]     state_r;
  logic [CW-1:0]  count_r;
  logic [2*R-1:0] rad_r;
  logic [R+1:0]   rem_part_r;
  logic [R-1:0]   q_r;
  logic [R-1:0]   root_r;
  logic [R:0]     rem_r;
  logic           out_valid_r;

  logic           in_ready_s;
  logic           accept_s;
  logic [2*R-1:0] rad_load_s;
  logic [R+1:0]   rem_c  [0:K];
  logic [R-1:0]   root_c [0:K];

  assign in_ready_s = rstN && ((state_r == IDLE) || ((state_r == DONE) && bus.outReady));
  assign accept_s   = bus.inValid && in_ready_s;
  // Radicand scaled by 4^FRAC and left-padded so odd N still pairs up from the MSB.
  assign rad_load_s = (2*R)'(bus.in) << (2 * FRAC);

  assign rem_c[0]  = rem_part_r;
  assign root_c[0] = q_r;

  for (genvar g = 0; g < K; g++) begin : g_digit
    int_sqrt_digit #(.R(R)) u_digit (
      .part_rem  (rem_c[g]),
      .part_root (root_c[g]),
      .pair      (rad_r[2*R-1-2*g -: 2]),
      .next_rem  (rem_c[g+1]),
      .next_root (root_c[g+1])
    );
  end

  // Control FSM plus partial-result and output registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_r     <= IDLE;
      count_r     <= {CW{1'b0}};
      rad_r       <= {(2*R){1'b0}};
      rem_part_r  <= {(R+2){1'b0}};
      q_r         <= {R{1'b0}};
      root_r      <= {R{1'b0}};
      rem_r       <= {(R+1){1'b0}};
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      state_r     <= RUN;
      count_r     <= {CW{1'b0}};
      rad_r       <= rad_load_s;
      rem_part_r  <= {(R+2){1'b0}};
      q_r         <= {R{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          rad_r      <= rad_r << (2 * K);
          rem_part_r <= rem_c[K];
          q_r        <= root_c[K];
          count_r    <= count_r + CW'(1'b1);
          if (count_r == CW'(ITERS - 1)) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            root_r      <= root_c[K];
            rem_r       <= rem_c[K][R:0];
          end
        end
        DONE: begin
          if (bus.outReady) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        IDLE: state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.inReady  = in_ready_s;
  assign bus.outValid = out_valid_r;
  assign bus.root     = root_r;
  assign bus.rem      = rem_r;

endmodule

// File: tb/tb_int_sqrt_iter.sv
// Scoreboard bench for int_sqrt_iter: four configurations (FRAC/K) in parallel,
// directed corner cases on the first, then randomized traffic on all.
module tb_int_sqrt_iter;

  typedef struct {
    longint unsigned root;
    longint unsigned rem;
    int              acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        in_valid    [4];
  logic [31:0] in_data     [4];
  logic        out_ready   [4];
  logic        in_ready_w  [4];
  logic        out_valid_w [4];
  logic [63:0] root_w      [4];
  logic [63:0] rem_w       [4];

  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  exp_t exp_q [4][$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic int frac_of(input int c);
    return (c == 3) ? 4 : 0;
  endfunction

  function automatic longint unsigned isqrt(input longint unsigned v);
    longint unsigned r;
    r = longint'($sqrt(real'(v)));
    while (r * r > v) r = r - 1;
    while ((r + 1) * (r + 1) <= v) r = r + 1;
    return r;
  endfunction

  function automatic exp_t make_exp(input int c, input logic [31:0] v);
    exp_t            e;
    longint unsigned full;
    full   = 64'(v) << (2 * frac_of(c));
    e.root = isqrt(full);
    e.rem  = full - e.root * e.root;
    e.acc  = 0;
    return e;
  endfunction

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  for (genvar c = 0; c < 4; c++) begin : g_cfg
    localparam int FRAC_C  = (c == 3) ? 4 : 0;
    localparam int K_C     = (c == 0) ? 1 : ((c == 2) ? 4 : 2);
    localparam int R_C     = 16 + FRAC_C;
    localparam int ITERS_C = R_C / K_C;

    int_sqrt_iter_if #(.N(32), .R(R_C)) bus ();

    assign bus.inValid    = in_valid[c];
    assign bus.in         = in_data[c];
    assign bus.outReady   = out_ready[c];
    assign in_ready_w[c]  = bus.inReady;
    assign out_valid_w[c] = bus.outValid;
    assign root_w[c]      = 64'(bus.root);
    assign rem_w[c]       = 64'(bus.rem);

    int_sqrt_iter #(.N(32), .FRAC(FRAC_C), .K(K_C)) dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus)
    );

    // Monitor: compare each new result with the scoreboard, then check it is held.
    initial begin : mon
      bit              seen;
      longint unsigned held_root;
      longint unsigned held_rem;
      exp_t            e;
      seen = 1'b0;
      held_root = 0;
      held_rem  = 0;
      forever begin
        @(negedge clk);
        if (!rstN) begin
          seen = 1'b0;
        end else begin
          if (out_valid_w[c] && !seen) begin
            seen      = 1'b1;
            held_root = root_w[c];
            held_rem  = rem_w[c];
            if (exp_q[c].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL c%0d_unexpected actual=root %0d required=no result", c, root_w[c]);
            end else begin
              e = exp_q[c].pop_front();
              check($sformatf("c%0d_root", c), root_w[c], e.root);
              check($sformatf("c%0d_rem", c), rem_w[c], e.rem);
              check($sformatf("c%0d_latency", c), longint'(cycle - e.acc), longint'(ITERS_C));
            end
          end else if (out_valid_w[c]) begin
            check($sformatf("c%0d_hold_root", c), root_w[c], held_root);
            check($sformatf("c%0d_hold_rem", c), rem_w[c], held_rem);
          end
          if (out_valid_w[c] && out_ready[c]) seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input int c, input logic [31:0] v, input bit rnd, output int acc);
    exp_t e;
    bit   ok;
    e = make_exp(c, v);
    @(posedge clk); #1;
    in_data[c]  = v;
    in_valid[c] = 1'b1;
    if (rnd) out_ready[c] = ($urandom_range(0, 3) != 0);
    ok  = 1'b0;
    acc = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (in_ready_w[c]) begin
        acc   = cycle + 1;
        e.acc = acc;
        exp_q[c].push_back(e);
        ok = 1'b1;
      end
      @(posedge clk); #1;
      if (ok) begin
        in_valid[c] = 1'b0;
        in_data[c]  = $urandom;
      end
      if (rnd) out_ready[c] = ($urandom_range(0, 3) != 0);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL c%0d_accept_timeout actual=no accept required=accept", c);
      in_valid[c] = 1'b0;
    end
  endtask

  task automatic drain(input int c);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      ok = (exp_q[c].size() == 0) && in_ready_w[c] && !out_valid_w[c];
    end
    check($sformatf("c%0d_drain", c), longint'(ok), 64'd1);
  endtask

  task automatic run_random(input int c);
    int          acc;
    logic [31:0] v;
    logic [31:0] r;
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 7))
        0: v = 32'd0;
        1: v = 32'hFFFF_FFFF;
        2: v = $urandom_range(0, 255);
        3: begin r = $urandom_range(0, 65535); v = r * r; end
        default: v = $urandom;
      endcase
      issue(c, v, 1'b1, acc);
    end
    @(posedge clk); #1;
    out_ready[c] = 1'b1;
    drain(c);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   acc;
    bit   seen_valid;
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      in_valid[c]  = 1'b0;
      in_data[c]   = 32'd0;
      out_ready[c] = 1'b1;
    end
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("c%0d_rst_in_ready", c), longint'(in_ready_w[c]), 64'd0);
      check($sformatf("c%0d_rst_out_valid", c), longint'(out_valid_w[c]), 64'd0);
      check($sformatf("c%0d_rst_root", c), root_w[c], 64'd0);
      check($sformatf("c%0d_rst_rem", c), rem_w[c], 64'd0);
    end
    rstN = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 4; c++)
      check($sformatf("c%0d_idle_in_ready", c), longint'(in_ready_w[c]), 64'd1);

    issue(0, 32'd0, 1'b0, acc);
    issue(0, 32'hFFFF_FFFF, 1'b0, acc);
    issue(0, 32'd1000000, 1'b0, acc);
    issue(0, 32'd99, 1'b0, acc);
    issue(3, 32'd2, 1'b0, acc);
    drain(0);
    drain(3);

    // Backpressure with a radicand pending behind an unconsumed result.
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    issue(0, 32'd5000, 1'b0, acc);
    seen_valid = 1'b0;
    for (int t = 0; t < 100 && !seen_valid; t++) begin
      @(negedge clk);
      seen_valid = out_valid_w[0];
    end
    check("bp_result_ready", longint'(seen_valid), 64'd1);
    @(posedge clk); #1;
    in_data[0]  = 32'd144;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", longint'(in_ready_w[0]), 64'd0);
      check("bp_out_valid", longint'(out_valid_w[0]), 64'd1);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", longint'(in_ready_w[0]), 64'd1);
    e     = make_exp(0, 32'd144);
    e.acc = cycle + 1;
    exp_q[0].push_back(e);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    drain(0);

    // Asynchronous reset while an operation is in flight at count 7.
    issue(0, 32'd12345678, 1'b0, acc);
    for (int t = 0; t < 50 && cycle != acc + 7; t++) begin
      @(posedge clk); #1;
    end
    #2;
    rstN = 1'b0;
    #1;
    check("midrst_out_valid", longint'(out_valid_w[0]), 64'd0);
    check("midrst_root", root_w[0], 64'd0);
    check("midrst_rem", rem_w[0], 64'd0);
    check("midrst_in_ready", longint'(in_ready_w[0]), 64'd0);
    exp_q[0].delete();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("postrst_out_valid", longint'(out_valid_w[0]), 64'd0);
      check("postrst_in_ready", longint'(in_ready_w[0]), 64'd1);
    end
    issue(0, 32'd49, 1'b0, acc);
    drain(0);

    for (int c = 0; c < 4; c++) begin
      automatic int cc = c;
      fork
        run_random(cc);
      join_none
    end
    wait fork;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
